mem_mgmt_unit: RTL
==================

# mem_mgmt_unit

Responder end of the instruction-fetch request/ready protocol: accepts a word-fetch request from `inst_fetcher`, reads four bytes serially from the byte-wide main RAM, and returns the assembled little-endian instruction with a one-cycle ready pulse. It sits between the fetch front end and the RAM/IO bus. An optional load/store data port shares the same RAM bus under fixed-priority arbitration.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of all addresses and of `mem_a`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `rdy`  in  1  global enable; when 0 every register holds its value.
- `valid_from_inst_fetcher`  in  1  fetch request, level, held until ready.
- `addr_from_inst_fetcher`  in  ADDR_WIDTH  byte address of the instruction.
- `ready_to_inst_fetcher`  out  1  one-cycle pulse; `inst_to_inst_fetcher` is valid.
- `inst_to_inst_fetcher`  out  32  assembled instruction; held until the next completion.
- `mem_din`  in  8  RAM read byte, one cycle after the address edge.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  ADDR_WIDTH  RAM byte address, registered.
- `mem_wr`  out  1  RAM write strobe, registered value ANDed with `rdy`.
- Data port (present only with `MEM_MGMT_DATA_PORT_EN`): `valid_from_lsb` in 1; `rw_from_lsb` in 1 (1 = write); `addr_from_lsb` in ADDR_WIDTH; `size_from_lsb` in 2 (0 = 1B, 1 = 2B, 2 = 4B, 3 treated as 4B); `data_from_lsb` in 32; `ready_to_lsb` out 1 pulse; `data_to_lsb` out 32, zero-extended read data.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: sample requests.
  - With the data port compiled in, a valid data request takes priority over an inst request.
  - Latch the address, requester, and byte count N (4 for inst).
  - Set `mem_a <= addr`.
  - On a write, also set `mem_dout <= byte0` and `mem_wr <= 1`.
  - Go to READ or WRITE.
- READ: each edge advances `mem_a` by 1 until the address of byte N-1 has been issued. From the second edge onward, `mem_din` is captured into byte lane k (k = 0..N-1). After byte N-1 is captured, set the requester's ready to 1, drive the data output, and go to DONE.
- WRITE: one byte per edge (`mem_a`, `mem_dout` advance together). After the edge that presents byte N-1, clear `mem_wr`, pulse the requester's ready, and go to DONE.
- DONE: exactly one cycle. Clear ready and return to IDLE. Requests are ignored in DONE, so a stale held request is never re-accepted.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFFFFFF + 1 wraps to 0. Unaligned addresses are legal.
- Assembly is little-endian: `inst = {b3, b2, b1, b0}`.
- Reset values: state IDLE; `ready_to_inst_fetcher` 0; `inst_to_inst_fetcher` 0; `mem_a` 0; `mem_dout` 0; `mem_wr` 0; `ready_to_lsb` 0; `data_to_lsb` 0.
- Reset mid-transaction aborts it: no ready pulse, and `mem_wr` drops in the next cycle.
- `rdy` = 0 mid-transaction freezes the counter and `mem_a`. No byte is captured or written, and `mem_wr` is forced to 0 at the output. The transaction resumes unchanged when `rdy` returns to 1.

## Timing
- Inst request accepted at edge T (state IDLE, valid = 1).
- Edge T: `mem_a` = A. Edges T+1..T+3: `mem_a` = A+1..A+3.
- Bytes are captured at edges T+2..T+5.
- Ready is high during the cycle after edge T+5 (latency 5). Ready is low again after T+6.
- The earliest next acceptance is edge T+7, which allows the requester to update valid and addr at T+6. Back-to-back period is 7 cycles.
- A data write of N bytes asserts ready after edge T+N−1+1, so a 1B write pulses ready after edge T+1.
- Ready is never asserted for two consecutive cycles.

## Configuration
- `MEM_MGMT_DATA_PORT_EN` defined: the data port exists, with data-over-inst priority and byte/half/word reads and writes.
- Not defined: the data-port ports are absent, `mem_wr` is constant 0, `mem_dout` is constant 0, and WRITE is unreachable. Inst behaviour and timing are identical in both builds.

## Test plan
- Reset, then inst fetch at 0x0 with RAM bytes 13 00 00 00 -> exactly one ready pulse 5 cycles after acceptance, `inst` = 0x00000013; all outputs 0 before the request.
- Fetcher holds valid and changes addr to 0x4 on the ready edge -> the second acceptance happens exactly 7 cycles after the first; no duplicate fetch of 0x0 (verified via the `mem_a` trace).
- Fetch at 0xFFFFFFFE -> `mem_a` sequence FFFFFFFE, FFFFFFFF, 0, 1; bytes assemble correctly.
- `rdy` low for 3 cycles mid-fetch -> ready is delayed by exactly 3 cycles; value unchanged; `mem_wr` stays 0.
- `rst` pulsed 2 cycles into a fetch -> no ready pulse; a new fetch afterwards completes normally.
- (DATA_PORT_EN) inst and lsb write (size 2, 0xDEADBEEF @0x100) requested in the same cycle -> `mem_wr` high for 4 cycles writing EF BE AD DE to 0x100..0x103, `ready_to_lsb` pulses, then the inst fetch starts and completes.

Source files
------------

// File: rtl/mem_mgmt_if.sv
// mem_mgmt_if
//   Bundles the fetch request/ready handshake, the byte-wide RAM bus and,
//   when MEM_MGMT_DATA_PORT_EN is defined, the load/store data port.
//
//   Handshake: a requester holds valid (and its address/command) high as a
//   level until the responder returns a one-cycle ready pulse. Result data
//   (inst_to_inst_fetcher / data_to_lsb) is valid during that pulse and is
//   held until the next completion for the same requester. A request still
//   held during the cycle after ready is not re-accepted.
//
//   Modports:
//     slave  - the memory management unit (responder, RAM bus driver)
//     master - the fetch front end / load-store unit / RAM model
//
//   Optional feature macro: MEM_MGMT_DATA_PORT_EN adds the data-port signals.
interface mem_mgmt_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  valid_from_inst_fetcher;
  logic [ADDR_WIDTH-1:0] addr_from_inst_fetcher;
  logic                  ready_to_inst_fetcher;
  logic [31:0]           inst_to_inst_fetcher;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

`ifdef MEM_MGMT_DATA_PORT_EN
  logic                  valid_from_lsb;
  logic                  rw_from_lsb;
  logic [ADDR_WIDTH-1:0] addr_from_lsb;
  logic [1:0]            size_from_lsb;
  logic [31:0]           data_from_lsb;
  logic                  ready_to_lsb;
  logic [31:0]           data_to_lsb;
`endif

  modport slave (
    input  valid_from_inst_fetcher,
    input  addr_from_inst_fetcher,
    input  mem_din,
    output ready_to_inst_fetcher,
    output inst_to_inst_fetcher,
    output mem_dout,
    output mem_a,
    output mem_wr
`ifdef MEM_MGMT_DATA_PORT_EN
    ,
    input  valid_from_lsb,
    input  rw_from_lsb,
    input  addr_from_lsb,
    input  size_from_lsb,
    input  data_from_lsb,
    output ready_to_lsb,
    output data_to_lsb
`endif
  );

  modport master (
    output valid_from_inst_fetcher,
    output addr_from_inst_fetcher,
    output mem_din,
    input  ready_to_inst_fetcher,
    input  inst_to_inst_fetcher,
    input  mem_dout,
    input  mem_a,
    input  mem_wr
`ifdef MEM_MGMT_DATA_PORT_EN
    ,
    output valid_from_lsb,
    output rw_from_lsb,
    output addr_from_lsb,
    output size_from_lsb,
    output data_from_lsb,
    input  ready_to_lsb,
    input  data_to_lsb
`endif
  );
endinterface

// File: rtl/mem_mgmt_unit.sv
// mem_mgmt_unit
//   Responder for instruction fetches: reads four bytes serially from the
//   byte-wide RAM and returns the little-endian word with a one-cycle ready
//   pulse (latency 5 edges after acceptance, back-to-back period 7).
//   With MEM_MGMT_DATA_PORT_EN defined, a load/store data port shares the
//   RAM bus and wins arbitration over instruction fetches; it supports 1, 2
//   and 4 byte reads (zero-extended) and writes.
//
//   Ports:
//     clk          clock
//     rst          synchronous active-high reset, aborts any transaction
//     rdy          global enable; 0 freezes every register, mem_wr forced 0
//     bus          mem_mgmt_if.slave (fetch handshake, RAM bus, data port)
//     dbg_state_o  current FSM state (IDLE/READ/WRITE/DONE)
//
//   mem_din is expected one cycle after the address edge, and the RAM read
//   register is assumed to sit in the same rdy-gated domain, so a stall
//   leaves the read pipeline aligned with mem_a.
module mem_mgmt_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_mgmt_if.slave  bus,
  output logic [1:0] dbg_state_o
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [2:0]            cnt_q;     // READ: edges taken; WRITE: bytes presented
  logic [2:0]            n_q;       // byte count of the current transaction
  logic [31:0]           buf_q;     // bytes captured so far, upper lanes zero
  logic [31:0]           cap_word;  // buf_q with this edge's byte merged in
  logic                  ready_inst_q;
  logic [31:0]           inst_q;

`ifdef MEM_MGMT_DATA_PORT_EN
  logic                  req_lsb_q;
  logic                  mem_wr_q;
  logic [7:0]            dout_q;
  logic [23:0]           wshift_q;  // bytes still to be written, next in [7:0]
  logic                  ready_lsb_q;
  logic [31:0]           data_lsb_q;
  logic [2:0]            lsb_n;

  assign lsb_n = (bus.size_from_lsb == 2'd0) ? 3'd1 :
                 (bus.size_from_lsb == 2'd1) ? 3'd2 : 3'd4;

  assign bus.mem_wr       = mem_wr_q & rdy;
  assign bus.mem_dout     = dout_q;
  assign bus.ready_to_lsb = ready_lsb_q;
  assign bus.data_to_lsb  = data_lsb_q;
`else
  assign bus.mem_wr       = 1'b0;
  assign bus.mem_dout     = 8'h00;
`endif

  assign bus.mem_a                 = mem_a_q;
  assign bus.ready_to_inst_fetcher = ready_inst_q;
  assign bus.inst_to_inst_fetcher  = inst_q;
  assign dbg_state_o               = state_q;

  // On READ edge k (k >= 1) mem_din carries byte k-1.
  always_comb begin
    cap_word = buf_q;
    case (cnt_q)
      3'd1:    cap_word[7:0]   = bus.mem_din;
      3'd2:    cap_word[15:8]  = bus.mem_din;
      3'd3:    cap_word[23:16] = bus.mem_din;
      3'd4:    cap_word[31:24] = bus.mem_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_a_q      <= '0;
      cnt_q        <= '0;
      n_q          <= '0;
      buf_q        <= '0;
      ready_inst_q <= 1'b0;
      inst_q       <= '0;
`ifdef MEM_MGMT_DATA_PORT_EN
      req_lsb_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      dout_q       <= '0;
      wshift_q     <= '0;
      ready_lsb_q  <= 1'b0;
      data_lsb_q   <= '0;
`endif
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          buf_q <= '0;
`ifdef MEM_MGMT_DATA_PORT_EN
          if (bus.valid_from_lsb) begin
            req_lsb_q <= 1'b1;
            n_q       <= lsb_n;
            mem_a_q   <= bus.addr_from_lsb;
            if (bus.rw_from_lsb) begin
              // Byte 0 goes out on the accepting edge itself.
              dout_q   <= bus.data_from_lsb[7:0];
              wshift_q <= bus.data_from_lsb[31:8];
              mem_wr_q <= 1'b1;
              cnt_q    <= 3'd1;
              state_q  <= WRITE;
            end else begin
              state_q  <= READ;
            end
          end else
`endif
          if (bus.valid_from_inst_fetcher) begin
`ifdef MEM_MGMT_DATA_PORT_EN
            req_lsb_q <= 1'b0;
`endif
            n_q     <= 3'd4;
            mem_a_q <= bus.addr_from_inst_fetcher;
            state_q <= READ;
          end
        end
        READ: begin
          if (cnt_q < n_q - 3'd1) mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
          if (cnt_q != 3'd0) buf_q <= cap_word;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == n_q) begin
            state_q <= DONE;
`ifdef MEM_MGMT_DATA_PORT_EN
            if (req_lsb_q) begin
              ready_lsb_q <= 1'b1;
              data_lsb_q  <= cap_word;
            end else begin
              ready_inst_q <= 1'b1;
              inst_q       <= cap_word;
            end
`else
            ready_inst_q <= 1'b1;
            inst_q       <= cap_word;
`endif
          end
        end
        WRITE: begin
`ifdef MEM_MGMT_DATA_PORT_EN
          if (cnt_q < n_q) begin
            mem_a_q  <= mem_a_q + ADDR_WIDTH'(1);
            dout_q   <= wshift_q[7:0];
            wshift_q <= {8'h00, wshift_q[23:8]};
            cnt_q    <= cnt_q + 3'd1;
          end else begin
            mem_wr_q    <= 1'b0;
            ready_lsb_q <= 1'b1;
            state_q     <= DONE;
          end
`else
          state_q <= IDLE;
`endif
        end
        DONE: begin
          // Held requests are ignored here so a stale valid is not re-taken.
          ready_inst_q <= 1'b0;
`ifdef MEM_MGMT_DATA_PORT_EN
          ready_lsb_q  <= 1'b0;
`endif
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
